fetch_byte_queue: RTL and testbench

- Parametrised circular instruction-byte queue between the memory arbiter (line fills) and the ID stage (variable-length decode window).
- Replaces the fixed 2x64-byte decode buffer and its duplicated-window trick with true head/tail pointers, wrap-around and occupancy tracking.
- Adds unaligned start skip, flush/redirect, and an explicit fill handshake.
- Generates the next line request address for the memory arbiter.

---
 rtl/fetch_byte_queue.sv | 150 +++++++++++++++
 tb/tb_fetch_byte_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_byte_queue.sv
// Circular instruction-byte queue between line fills from the memory arbiter and the
// variable-length decode window, with head/tail pointers, unaligned start skip and flush.
module fetch_byte_queue #(
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned NUM_LINES  = 2,
    parameter int unsigned WIN_BYTES  = 15,
    parameter int unsigned ADDR_W     = 64
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         flush,
    input  logic [ADDR_W-1:0]                            flush_addr,
    output logic [ADDR_W-1:0]                            req_addr,
    input  logic                                         fill_valid,
    output logic                                         fill_ready,
    input  logic [LINE_BYTES*8-1:0]                      fill_data,
    output logic [WIN_BYTES*8-1:0]                       win_bytes,
    output logic [$clog2(WIN_BYTES+1)-1:0]               win_count,
    output logic                                         win_full,
    output logic [ADDR_W-1:0]                            win_pc,
    input  logic [$clog2(WIN_BYTES+1)-1:0]               consume,
    output logic [$clog2(LINE_BYTES*NUM_LINES+1)-1:0]    count,
    output logic                                         err
);

    localparam int unsigned CAP   = LINE_BYTES * NUM_LINES;
    localparam int unsigned PTR_W = $clog2(CAP);
    localparam int unsigned CNT_W = $clog2(CAP + 1);
    localparam int unsigned WC_W  = $clog2(WIN_BYTES + 1);
    localparam int unsigned OFF_W = $clog2(LINE_BYTES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [ADDR_W-1:0]  win_pc_q, win_pc_d;
    logic [OFF_W-1:0]   skip_q, skip_d;
    logic               err_q, err_d;
    logic [7:0]         mem_q [CAP];
    logic [7:0]         mem_d [CAP];

    logic               fill_acc;
    logic [WC_W-1:0]    cons_amt;
    logic [CNT_W-1:0]   added;
    logic [PTR_W-1:0]   widx;

    assign req_addr   = req_addr_q;
    assign win_pc     = win_pc_q;
    assign count      = count_q;
    assign err        = err_q;
    assign win_full   = (count_q >= CNT_W'(WIN_BYTES));
    assign win_count  = win_full ? WC_W'(WIN_BYTES) : WC_W'(count_q);
    // Only registered occupancy gates a fill; a same-cycle consume earns no credit.
    assign fill_ready = (state_q == RUN) && (count_q <= CNT_W'(CAP - LINE_BYTES));

    always_comb begin
        win_bytes = '0;
        for (int unsigned i = 0; i < WIN_BYTES; i++) begin
            if (WC_W'(i) < win_count) begin
                win_bytes[8*i +: 8] = mem_q[PTR_W'(rd_ptr_q + PTR_W'(i))];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        req_addr_d = req_addr_q;
        win_pc_d   = win_pc_q;
        skip_d     = skip_q;
        err_d      = err_q;
        mem_d      = mem_q;
        fill_acc   = 1'b0;
        cons_amt   = '0;
        added      = '0;
        widx       = '0;

        if (flush) begin
            state_d    = RUN;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            win_pc_d   = flush_addr;
            req_addr_d = {flush_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            skip_d     = flush_addr[OFF_W-1:0];
        end else if (state_q == IDLE) begin
            if (consume != '0) begin
                err_d = 1'b1;
            end
        end else begin
            fill_acc = fill_valid && fill_ready;
            if (consume <= win_count) begin
                cons_amt = consume;
            end else begin
                err_d = 1'b1;
            end

            if (fill_acc) begin
                // Leading skip bytes are dropped; the rest pack contiguously from wr_ptr.
                for (int unsigned j = 0; j < LINE_BYTES; j++) begin
                    if (OFF_W'(j) >= skip_q) begin
                        widx        = wr_ptr_q + PTR_W'(j) - PTR_W'(skip_q);
                        mem_d[widx] = fill_data[8*j +: 8];
                    end
                end
                added      = CNT_W'(LINE_BYTES) - CNT_W'(skip_q);
                wr_ptr_d   = wr_ptr_q + PTR_W'(LINE_BYTES) - PTR_W'(skip_q);
                req_addr_d = req_addr_q + ADDR_W'(LINE_BYTES);
                skip_d     = '0;
            end

            rd_ptr_d = rd_ptr_q + PTR_W'(cons_amt);
            win_pc_d = win_pc_q + ADDR_W'(cons_amt);
            count_d  = count_q + added - CNT_W'(cons_amt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            req_addr_q <= '0;
            win_pc_q   <= '0;
            skip_q     <= '0;
            err_q      <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            req_addr_q <= req_addr_d;
            win_pc_q   <= win_pc_d;
            skip_q     <= skip_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed bench for fetch_byte_queue: reset, fills, unaligned start, wrap, concurrent
// fill/consume, protocol errors, flush and reset during activity.
module tb_fetch_byte_queue;

    localparam int unsigned LB = 64;
    localparam int unsigned NL = 2;
    localparam int unsigned WB = 15;
    localparam int unsigned AW = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [AW-1:0]     flush_addr;
    logic [AW-1:0]     req_addr;
    logic              fill_valid;
    logic              fill_ready;
    logic [LB*8-1:0]   fill_data;
    logic [WB*8-1:0]   win_bytes;
    logic [3:0]        win_count;
    logic              win_full;
    logic [AW-1:0]     win_pc;
    logic [3:0]        consume;
    logic [7:0]        count;
    logic              err;

    int n_cmp = 0;
    int n_err = 0;

    fetch_byte_queue #(
        .LINE_BYTES(LB),
        .NUM_LINES (NL),
        .WIN_BYTES (WB),
        .ADDR_W    (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .flush_addr(flush_addr),
        .req_addr  (req_addr),
        .fill_valid(fill_valid),
        .fill_ready(fill_ready),
        .fill_data (fill_data),
        .win_bytes (win_bytes),
        .win_count (win_count),
        .win_full  (win_full),
        .win_pc    (win_pc),
        .consume   (consume),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [AW-1:0] a);
        flush = 1'b1;
        flush_addr = a;
        step();
        flush = 1'b0;
    endtask

    task automatic set_line(input logic [7:0] base);
        for (int k = 0; k < LB; k++) fill_data[8*k +: 8] = base + 8'(k);
    endtask

    task automatic do_fill(input logic [7:0] base);
        set_line(base);
        fill_valid = 1'b1;
        step();
        fill_valid = 1'b0;
    endtask

    task automatic do_consume(input logic [3:0] n);
        consume = n;
        step();
        consume = '0;
    endtask

    // Window image holding n ascending bytes starting at value base, zeros above.
    function automatic logic [WB*8-1:0] make_win(input logic [7:0] base, input int n);
        logic [WB*8-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = base + 8'(i);
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; flush_addr = '0; fill_valid = 1'b0; fill_data = '0; consume = '0;
        #12;
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", count); end
        n_cmp++; if (req_addr !== 64'h0) begin n_err++; $display("FAIL rst_req got %h exp 0", req_addr); end
        n_cmp++; if (win_pc !== 64'h0) begin n_err++; $display("FAIL rst_pc got %h exp 0", win_pc); end
        n_cmp++; if (fill_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", fill_ready); end
        n_cmp++; if (win_count !== 4'd0 || win_full !== 1'b0) begin n_err++; $display("FAIL rst_win got cnt %0d full %b exp 0 0", win_count, win_full); end
        n_cmp++; if (win_bytes !== '0 || err !== 1'b0) begin n_err++; $display("FAIL rst_bytes_err got %h err %b exp 0 0", win_bytes, err); end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_fill();
        do_flush(64'h1000);
        n_cmp++; if (req_addr !== 64'h1000 || win_pc !== 64'h1000) begin n_err++; $display("FAIL flush_addr got req %h pc %h exp 1000 1000", req_addr, win_pc); end
        n_cmp++; if (fill_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b exp 1", fill_ready); end
        do_fill(8'h00);
        n_cmp++; if (count !== 8'd64) begin n_err++; $display("FAIL fill1_count got %0d exp 64", count); end
        n_cmp++; if (req_addr !== 64'h1040 || win_pc !== 64'h1000) begin n_err++; $display("FAIL fill1_addr got req %h pc %h exp 1040 1000", req_addr, win_pc); end
        n_cmp++; if (win_bytes !== make_win(8'h00, 15)) begin n_err++; $display("FAIL fill1_win got %h exp %h", win_bytes, make_win(8'h00, 15)); end
        n_cmp++; if (win_full !== 1'b1 || win_count !== 4'd15 || fill_ready !== 1'b1) begin n_err++; $display("FAIL fill1_flags got full %b cnt %0d rdy %b exp 1 15 1", win_full, win_count, fill_ready); end
        do_fill(8'h40);
        n_cmp++; if (count !== 8'd128 || fill_ready !== 1'b0) begin n_err++; $display("FAIL fill2 got count %0d rdy %b exp 128 0", count, fill_ready); end
        n_cmp++; if (req_addr !== 64'h1080) begin n_err++; $display("FAIL fill2_req got %h exp 1080", req_addr); end
        // Held fill_valid while full must not change anything.
        do_fill(8'hA0);
        n_cmp++; if (count !== 8'd128 || req_addr !== 64'h1080) begin n_err++; $display("FAIL full_fill got count %0d req %h exp 128 1080", count, req_addr); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 8; r++) do_consume(4'd15);
        n_cmp++; if (count !== 8'd8 || win_count !== 4'd8 || win_full !== 1'b0) begin n_err++; $display("FAIL wrap_drain got count %0d wc %0d full %b exp 8 8 0", count, win_count, win_full); end
        n_cmp++; if (win_pc !== 64'h1078) begin n_err++; $display("FAIL wrap_pc got %h exp 1078", win_pc); end
        n_cmp++; if (win_bytes !== make_win(8'h78, 8)) begin n_err++; $display("FAIL wrap_partial got %h exp %h", win_bytes, make_win(8'h78, 8)); end
        do_fill(8'h80);
        n_cmp++; if (count !== 8'd72 || req_addr !== 64'h10C0) begin n_err++; $display("FAIL wrap_fill got count %0d req %h exp 72 10c0", count, req_addr); end
        n_cmp++; if (win_bytes !== make_win(8'h78, 15)) begin n_err++; $display("FAIL wrap_win got %h exp %h", win_bytes, make_win(8'h78, 15)); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL wrap_err got %b exp 0", err); end
    endtask

    task automatic test_unaligned();
        do_flush(64'h100D);
        n_cmp++; if (req_addr !== 64'h1000 || win_pc !== 64'h100D || count !== 8'd0) begin n_err++; $display("FAIL unal_flush got req %h pc %h count %0d exp 1000 100d 0", req_addr, win_pc, count); end
        do_fill(8'h00);
        n_cmp++; if (count !== 8'd51) begin n_err++; $display("FAIL unal_count got %0d exp 51", count); end
        n_cmp++; if (req_addr !== 64'h1040 || win_pc !== 64'h100D) begin n_err++; $display("FAIL unal_addr got req %h pc %h exp 1040 100d", req_addr, win_pc); end
        n_cmp++; if (win_bytes !== make_win(8'h0D, 15)) begin n_err++; $display("FAIL unal_win got %h exp %h", win_bytes, make_win(8'h0D, 15)); end
    endtask

    task automatic test_back_to_back();
        do_flush(64'h2000);
        do_fill(8'h00);
        n_cmp++; if (count !== 8'd64) begin n_err++; $display("FAIL b2b_pre got %0d exp 64", count); end
        set_line(8'h40);
        fill_valid = 1'b1;
        consume = 4'd7;
        step();
        fill_valid = 1'b0;
        consume = '0;
        n_cmp++; if (count !== 8'd121 || win_pc !== 64'h2007) begin n_err++; $display("FAIL b2b got count %0d pc %h exp 121 2007", count, win_pc); end
        n_cmp++; if (win_bytes !== make_win(8'h07, 15) || fill_ready !== 1'b0) begin n_err++; $display("FAIL b2b_win got %h rdy %b exp %h 0", win_bytes, fill_ready, make_win(8'h07, 15)); end
    endtask

    task automatic test_illegal_consume();
        do_flush(64'h3000);
        do_fill(8'h00);
        for (int r = 0; r < 4; r++) do_consume(4'd15);
        n_cmp++; if (count !== 8'd4 || win_pc !== 64'h303C || err !== 1'b0) begin n_err++; $display("FAIL ill_pre got count %0d pc %h err %b exp 4 303c 0", count, win_pc, err); end
        do_consume(4'd10);
        n_cmp++; if (count !== 8'd4 || win_pc !== 64'h303C) begin n_err++; $display("FAIL ill_nochange got count %0d pc %h exp 4 303c", count, win_pc); end
        n_cmp++; if (err !== 1'b1 || win_bytes !== make_win(8'h3C, 4)) begin n_err++; $display("FAIL ill_err got err %b win %h exp 1 %h", err, win_bytes, make_win(8'h3C, 4)); end
        do_flush(64'h4000);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL ill_sticky got %b exp 1", err); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL ill_rstclr got %b exp 0", err); end
        do_consume(4'd3);
        n_cmp++; if (err !== 1'b1 || count !== 8'd0) begin n_err++; $display("FAIL idle_consume got err %b count %0d exp 1 0", err, count); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_flush_reset();
        do_flush(64'h5000);
        do_fill(8'h00);
        n_cmp++; if (count !== 8'd64) begin n_err++; $display("FAIL fr_pre got %0d exp 64", count); end
        set_line(8'h40);
        fill_valid = 1'b1;
        consume = 4'd5;
        flush = 1'b1;
        flush_addr = 64'h6123;
        step();
        flush = 1'b0; fill_valid = 1'b0; consume = '0;
        n_cmp++; if (count !== 8'd0 || win_count !== 4'd0) begin n_err++; $display("FAIL fr_drop got count %0d wc %0d exp 0 0", count, win_count); end
        n_cmp++; if (req_addr !== 64'h6100 || win_pc !== 64'h6123) begin n_err++; $display("FAIL fr_addr got req %h pc %h exp 6100 6123", req_addr, win_pc); end
        do_fill(8'h00);
        n_cmp++; if (count !== 8'd29 || win_bytes !== make_win(8'h23, 15)) begin n_err++; $display("FAIL fr_fill got count %0d win %h exp 29 %h", count, win_bytes, make_win(8'h23, 15)); end
        reset = 1'b1;
        #2;
        n_cmp++; if (fill_ready !== 1'b0 || win_count !== 4'd0 || count !== 8'd0) begin n_err++; $display("FAIL async_rst got rdy %b wc %0d count %0d exp 0 0 0", fill_ready, win_count, count); end
        @(negedge clk); reset = 1'b0;
        do_fill(8'h00);
        n_cmp++; if (count !== 8'd0 || fill_ready !== 1'b0 || win_bytes !== '0) begin n_err++; $display("FAIL idle_fill got count %0d rdy %b win %h exp 0 0 0", count, fill_ready, win_bytes); end
        do_flush(64'h7000);
        do_fill(8'h00);
        n_cmp++; if (count !== 8'd64 || req_addr !== 64'h7040) begin n_err++; $display("FAIL refill got count %0d req %h exp 64 7040", count, req_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_wrap();
        test_unaligned();
        test_back_to_back();
        test_illegal_consume();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
